// File: rtl/traffic_light_safety_monitor_pkg.sv
// traffic_light_pkg: lamp encodings, road indices, fault codes and FSM states
package traffic_light_pkg;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] AMBER = 3'b010;
    localparam logic [2:0] GREEN = 3'b001;
    localparam logic [2:0] DARK  = 3'b000;
    localparam int ROAD_M1 = 0;
    localparam int ROAD_M2 = 1;
    localparam int ROAD_MT = 2;
    localparam int ROAD_S  = 3;
    localparam logic [2:0] FC_NONE      = 3'd0;
    localparam logic [2:0] FC_ENCODING  = 3'd1;
    localparam logic [2:0] FC_CONFLICT  = 3'd2;
    localparam logic [2:0] FC_GREEN_RED = 3'd3;
    localparam logic [2:0] FC_SHORT_AMB = 3'd4;
    localparam logic [2:0] FC_AMB_GREEN = 3'd5;
    typedef enum logic {MONITOR, FAULT} state_t;
endpackage

// File: rtl/traffic_light_safety_monitor_if.sv
// traffic_light_safety_monitor_if: controller lamp vectors in, checked lamp vectors and fault status out
interface traffic_light_safety_monitor_if;
    logic [2:0] light_M1, light_M2, light_MT, light_S;
    logic       clear_fault;
    logic [2:0] mon_M1, mon_M2, mon_MT, mon_S;
    logic       fault;
    logic [2:0] fault_code;
    logic [1:0] fault_road;
    modport master (
        output light_M1, light_M2, light_MT, light_S, clear_fault,
        input  mon_M1, mon_M2, mon_MT, mon_S, fault, fault_code, fault_road
    );
    modport slave (
        input  light_M1, light_M2, light_MT, light_S, clear_fault,
        output mon_M1, mon_M2, mon_MT, mon_S, fault, fault_code, fault_road
    );
endinterface

// File: rtl/traffic_light_safety_monitor_road_checker.sv
// light_road_checker: per-road encoding, open and amber-sequencing checks against the previous sample
module light_road_checker
    import traffic_light_pkg::*;
#(
    parameter int MIN_AMBER = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] cur,
    input  logic       upd,
    input  logic       load,
    output logic       illegal,
    output logic       open,
    output logic       f_g2r,
    output logic       f_short,
    output logic       f_a2g
);
    localparam int CW = $clog2(MIN_AMBER + 1);
    logic [2:0]    prev;
    logic [CW-1:0] cnt;
    // previous sample and saturating amber run length; frozen unless updating or reloading
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= RED;
            cnt  <= '0;
        end else if (load) begin
            prev <= cur;
            cnt  <= '0;
        end else if (upd) begin
            prev <= cur;
            cnt  <= cur != AMBER ? '0 : cnt == CW'(MIN_AMBER) ? cnt : cnt + CW'(1);
        end
    end
    assign illegal = !(cur == RED || cur == AMBER || cur == GREEN);
    assign open    = cur == GREEN || cur == AMBER;
    assign f_g2r   = prev == GREEN && cur == RED;
    assign f_a2g   = prev == AMBER && cur == GREEN;
    assign f_short = prev == AMBER && cur == RED && cnt < CW'(MIN_AMBER);
endmodule

// File: rtl/traffic_light_safety_monitor.sv
// traffic_light_safety_monitor: checks controller lamp vectors and forces flashing red on any violation
module traffic_light_safety_monitor
    import traffic_light_pkg::*;
#(
    parameter int MIN_AMBER  = 2,
    parameter int FLASH_HALF = 1
) (
    input logic clk,
    input logic rst,
    traffic_light_safety_monitor_if.slave bus
);
    localparam int FW = FLASH_HALF > 1 ? $clog2(FLASH_HALF) : 1;
    logic [2:0]      s1 [4];
    logic [2:0]      mon [4];
    logic            clr_ok, phase, all_red, clr_go, fwrap, ph_n;
    logic [FW-1:0]   fcnt;
    state_t          state;
    logic [3:0]      ill, opn, f3, f4, f5, cfl;
    logic [4:0][3:0] fl;
    logic [2:0]      code_n, code_q;
    logic [1:0]      road_n, road_q;
    logic            fault_q;
    assign all_red = s1[0] == RED && s1[1] == RED && s1[2] == RED && s1[3] == RED;
    assign clr_go  = state == FAULT && clr_ok;
    // stage 1: register the controller vectors; qualify a clear request against the sample it meets
    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= '{default: RED};
            clr_ok <= 1'b0;
        end else begin
            s1[ROAD_M1] <= bus.light_M1;
            s1[ROAD_M2] <= bus.light_M2;
            s1[ROAD_MT] <= bus.light_MT;
            s1[ROAD_S]  <= bus.light_S;
            clr_ok      <= state == FAULT && bus.clear_fault && all_red;
        end
    end
    for (genvar i = 0; i < 4; i++) begin : g_road
        light_road_checker #(.MIN_AMBER(MIN_AMBER)) u_chk (
            .clk     (clk),
            .rst     (rst),
            .cur     (s1[i]),
            .upd     (state == MONITOR),
            .load    (clr_go),
            .illegal (ill[i]),
            .open    (opn[i]),
            .f_g2r   (f3[i]),
            .f_short (f4[i]),
            .f_a2g   (f5[i])
        );
    end
    assign cfl = {1'b0, opn[ROAD_MT] & opn[ROAD_S], opn[ROAD_M2] & (opn[ROAD_MT] | opn[ROAD_S]),
                  opn[ROAD_M1] & opn[ROAD_S]};
    assign fl  = {f5, f4, f3, cfl, ill};
    // priority encode: scanning from the highest code/road down lets the lowest one win
    always_comb begin
        code_n = FC_NONE;
        road_n = 2'd0;
        for (int c = 4; c >= 0; c--)
            for (int r = 3; r >= 0; r--)
                if (fl[c][r]) begin
                    code_n = 3'(c + 1);
                    road_n = 2'(r);
                end
    end
    assign fwrap = fcnt == FW'(FLASH_HALF - 1);
    assign ph_n  = fwrap ? ~phase : phase;
    // monitor/fault FSM with registered lamp outputs and flash timing
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= MONITOR;
            mon     <= '{default: RED};
            fault_q <= 1'b0;
            code_q  <= FC_NONE;
            road_q  <= 2'd0;
            fcnt    <= '0;
            phase   <= 1'b0;
        end else if (state == MONITOR) begin
            if (code_n != FC_NONE) begin
                state   <= FAULT;
                mon     <= '{default: RED};
                fault_q <= 1'b1;
                code_q  <= code_n;
                road_q  <= road_n;
                fcnt    <= '0;
                phase   <= 1'b0;
            end else begin
                mon <= s1;
            end
        end else if (clr_go) begin
            state   <= MONITOR;
            mon     <= s1;
            fault_q <= 1'b0;
            code_q  <= FC_NONE;
            road_q  <= 2'd0;
            fcnt    <= '0;
            phase   <= 1'b0;
        end else begin
            fcnt  <= fwrap ? '0 : fcnt + FW'(1);
            phase <= ph_n;
            mon   <= '{default: ph_n ? DARK : RED};
        end
    end
    assign bus.mon_M1     = mon[ROAD_M1];
    assign bus.mon_M2     = mon[ROAD_M2];
    assign bus.mon_MT     = mon[ROAD_MT];
    assign bus.mon_S      = mon[ROAD_S];
    assign bus.fault      = fault_q;
    assign bus.fault_code = code_q;
    assign bus.fault_road = road_q;
endmodule
